// File: rtl/barcode_tx.sv
// Pulse-width barcode serializer: one start cell then 8 data cells (MSB first), then an idle gap.
// All timing scales with a period latched when the frame is accepted.
module barcode_tx #(
    parameter int unsigned PW    = 22,
    parameter int unsigned MIN_P = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic [7:0]    id,
    input  logic [PW-1:0] period,
    output logic          BC,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        StIdle,
        StStartLo,
        StStartHi,
        StBitLo,
        StBitHi,
        StGap
    } state_t;

    localparam logic [PW-1:0] MinP   = PW'(MIN_P);
    localparam logic [PW-1:0] OneP   = PW'(1);
    localparam logic [PW:0]   OneX   = (PW+1)'(1);

    state_t        r_state;
    logic [PW-1:0] r_timer;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [PW-1:0] r_peff;
    logic [PW-1:0] r_half;

    logic [PW-1:0] w_peff_req;
    logic          w_tmr_zero;
    logic          w_lo_bit;
    logic [PW:0]   w_peff_x;
    logic [PW:0]   w_half_x;
    logic [PW:0]   w_lo_len;
    logic [PW:0]   w_hi_len;
    logic [PW-1:0] w_lo_load;
    logic [PW-1:0] w_hi_load;

    assign w_peff_req = (period < MinP) ? MinP : period;
    assign w_tmr_zero = (r_timer == '0);
    assign w_peff_x   = {1'b0, r_peff};
    assign w_half_x   = {1'b0, r_half};

    // The low segment about to start belongs to the next bit after a shift when leaving BIT_HI.
    assign w_lo_bit  = (r_state == StBitHi) ? r_shift[6] : r_shift[7];
    assign w_lo_len  = w_lo_bit ? w_half_x : (w_peff_x + w_half_x);
    assign w_hi_len  = r_shift[7] ? ((w_peff_x << 1) - w_half_x) : (w_peff_x - w_half_x);
    assign w_lo_load = PW'(w_lo_len - OneX);
    assign w_hi_load = PW'(w_hi_len - OneX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_peff   <= '0;
            r_half   <= '0;
            BC       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                StIdle: begin
                    BC   <= 1'b1;
                    busy <= 1'b0;
                    if (send) begin
                        r_shift  <= id;
                        r_peff   <= w_peff_req;
                        r_half   <= w_peff_req >> 1;
                        r_timer  <= w_peff_req - OneP;
                        r_bitcnt <= '0;
                        BC       <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= StStartLo;
                    end
                end
                StStartLo: begin
                    if (w_tmr_zero) begin
                        r_timer <= r_peff - OneP;
                        BC      <= 1'b1;
                        r_state <= StStartHi;
                    end else begin
                        r_timer <= r_timer - OneP;
                    end
                end
                StStartHi: begin
                    if (w_tmr_zero) begin
                        r_timer <= w_lo_load;
                        BC      <= 1'b0;
                        r_state <= StBitLo;
                    end else begin
                        r_timer <= r_timer - OneP;
                    end
                end
                StBitLo: begin
                    if (w_tmr_zero) begin
                        r_timer <= w_hi_load;
                        BC      <= 1'b1;
                        r_state <= StBitHi;
                    end else begin
                        r_timer <= r_timer - OneP;
                    end
                end
                StBitHi: begin
                    if (w_tmr_zero) begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_timer <= r_peff - OneP;
                            r_state <= StGap;
                        end else begin
                            r_timer <= w_lo_load;
                            BC      <= 1'b0;
                            r_state <= StBitLo;
                        end
                    end else begin
                        r_timer <= r_timer - OneP;
                    end
                end
                StGap: begin
                    if (w_tmr_zero) begin
                        BC      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_timer <= r_timer - OneP;
                    end
                end
                default: begin
                    BC      <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barcode_tx.sv
// Bench for barcode_tx: stimulus pushes expected BC run lengths and frame records into queues;
// a negedge monitor measures runs on BC while busy, decodes the ID and compares.
module tb_barcode_tx;

    localparam int PW = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          send = 1'b0;
    logic [7:0]    id = 8'h00;
    logic [PW-1:0] period = '0;
    logic          BC;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    barcode_tx #(
        .PW    (PW),
        .MIN_P (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .send   (send),
        .id     (id),
        .period (period),
        .BC     (BC),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    typedef struct {
        int         peff;
        logic [7:0] id;
    } frm_t;

    seg_t seg_q[$];
    frm_t frm_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int frames_exp = 0;
    int dones_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic in_frame = 1'b0;
    logic cur_lvl = 1'b1;
    int   run_len = 0;
    int   busy_len = 0;
    int   lows[$];

    task automatic close_run();
        seg_t e;
        if (seg_q.size() == 0) begin
            chk("seg_unexpected", 32'd1, 32'd0);
        end else begin
            e = seg_q.pop_front();
            chk("seg_level", {31'd0, cur_lvl}, {31'd0, e.lvl});
            chk("seg_len", run_len, e.len);
        end
        if (!cur_lvl) lows.push_back(run_len);
    endtask

    task automatic close_frame();
        frm_t       f;
        logic [7:0] dec;
        close_run();
        chk("done_at_frame_end", {31'd0, done}, 32'd1);
        if (frm_q.size() == 0) begin
            chk("frame_unexpected", 32'd1, 32'd0);
        end else begin
            f = frm_q.pop_front();
            chk("busy_cycles", busy_len, 19 * f.peff);
            chk("low_run_count", lows.size(), 9);
            dec = 8'h00;
            // Receiver rule: BC sampled Peff after each fall is high only for short lows.
            if (lows.size() == 9)
                for (int i = 1; i <= 8; i++) dec = {dec[6:0], (lows[i] < f.peff)};
            chk("decoded_id", {24'd0, dec}, {24'd0, f.id});
        end
        lows.delete();
        in_frame = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            lows.delete();
        end else begin
            if (done) dones_seen++;
            if (busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_lvl  = BC;
                    run_len  = 1;
                    busy_len = 1;
                end else begin
                    busy_len++;
                    if (BC == cur_lvl) begin
                        run_len++;
                    end else begin
                        close_run();
                        cur_lvl = BC;
                        run_len = 1;
                    end
                end
            end else if (in_frame) begin
                close_frame();
            end else if (done) begin
                chk("spurious_done", 32'd1, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] v, input int p, input int peff, input bit now);
        int   h;
        int   lo;
        int   hi;
        seg_t s;
        frm_t f;
        if (!now) @(negedge clk);
        id     = v;
        period = PW'(p);
        send   = 1'b1;
        h = peff / 2;
        s.lvl = 1'b0; s.len = peff; seg_q.push_back(s);
        s.lvl = 1'b1; s.len = peff; seg_q.push_back(s);
        for (int i = 7; i >= 0; i--) begin
            lo = v[i] ? h : peff + h;
            hi = v[i] ? 2 * peff - h : peff - h;
            if (i == 0) hi += peff;  // last high merges with the gap
            s.lvl = 1'b0; s.len = lo; seg_q.push_back(s);
            s.lvl = 1'b1; s.len = hi; seg_q.push_back(s);
        end
        f.peff = peff;
        f.id   = v;
        frm_q.push_back(f);
        frames_exp++;
        @(posedge clk);
        #1 send = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("reset_BC", {31'd0, BC}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (BC !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        // A5 at P=8, with an ignored mid-frame send carrying a different id.
        issue(8'hA5, 8, 8, 1'b0);
        repeat (30) @(negedge clk);
        id = 8'h00; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done(200);

        // Back-to-back: send during the done cycle.
        issue(8'h3C, 1000, 1000, 1'b1);
        chk("b2b_BC_low", {31'd0, BC}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        period = PW'(5);
        wait_done(19100);

        issue(8'h00, 20, 20, 1'b0);
        wait_done(400);
        issue(8'hFF, 20, 20, 1'b0);
        wait_done(400);

        // Requested period below minimum is raised to 8.
        issue(8'h5A, 3, 8, 1'b0);
        wait_done(200);

        // Abort during data cell 4, then a clean frame.
        issue(8'hA5, 8, 8, 1'b0);
        repeat (70) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_BC", {31'd0, BC}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        seg_q.delete();
        frm_q.delete();
        frames_exp--;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(8'h96, 10, 10, 1'b0);
        wait_done(300);

        repeat (10) @(negedge clk);
        chk("done_pulse_count", dones_seen, frames_exp);
        chk("segments_left", seg_q.size(), 0);
        chk("frames_left", frm_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
